// File: rtl/riscv_retire_monitor_pkg.sv
// Shared definitions for the retire monitor: RV32I major opcodes,
// halt cause encodings and the monitor state enum.
package riscv_retire_monitor_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] HC_NONE    = 2'b00;
    localparam logic [1:0] HC_SYSTEM  = 2'b01;
    localparam logic [1:0] HC_ILLEGAL = 2'b10;
    localparam logic [1:0] HC_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_REPORT,
        ST_HALTED
    } state_t;

endpackage

// File: rtl/riscv_opcode_legal.sv
// Combinational RV32I opcode classifier: legal major opcode, and SYSTEM.
// Shared between the decoder and the retire monitor.
module riscv_opcode_legal
    import riscv_retire_monitor_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic       system
);

    always_comb begin
        legal  = 1'b0;
        system = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE: begin
                legal = 1'b1;
            end
            OP_SYSTEM: begin
                legal  = 1'b1;
                system = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_retire_monitor.sv
// Watches the MEM_WB retire stream, detects end of program (SYSTEM, illegal
// opcode or timeout), drains the pipe and hands a halt report to the host.
module riscv_retire_monitor
    import riscv_retire_monitor_pkg::*;
#(
    parameter int PC_WIDTH     = 32,
    parameter int CNT_WIDTH    = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int MAX_CYCLES   = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wb_valid,
    input  logic [6:0]           wb_opcode,
    input  logic [PC_WIDTH-1:0]  wb_pc,
    input  logic                 restart,
    output logic                 report_valid,
    input  logic                 report_ready,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [PC_WIDTH-1:0]  halt_pc,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_AT = CNT_WIDTH'(MAX_CYCLES - 1);
    localparam logic [3:0]           DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t               state, state_nx;
    logic [3:0]           drain_cnt, drain_nx;
    logic [CNT_WIDTH-1:0] ret_nx, cyc_nx;
    logic [1:0]           cause_nx, evt_cause;
    logic [PC_WIDTH-1:0]  pc_nx;
    logic                 legal, system, timeout;

    riscv_opcode_legal u_legal (
        .opcode (wb_opcode),
        .legal  (legal),
        .system (system)
    );

    assign timeout = (MAX_CYCLES != 0) && (cycle_count == TIMEOUT_AT);

    // Opcode causes outrank a timeout landing on the same edge
    always_comb begin
        evt_cause = HC_NONE;
        if (wb_valid && system)
            evt_cause = HC_SYSTEM;
        else if (wb_valid && !legal)
            evt_cause = HC_ILLEGAL;
        else if (timeout)
            evt_cause = HC_TIMEOUT;
    end

    always_comb begin
        state_nx = state;
        drain_nx = drain_cnt;
        ret_nx   = retired_count;
        cyc_nx   = cycle_count;
        cause_nx = halt_cause;
        pc_nx    = halt_pc;
        unique case (state)
            ST_RUN: begin
                if (cycle_count != CNT_MAX)
                    cyc_nx = cycle_count + 1'b1;
                if (wb_valid && legal && retired_count != CNT_MAX)
                    ret_nx = retired_count + 1'b1;
                if (evt_cause != HC_NONE) begin
                    cause_nx = evt_cause;
                    pc_nx    = (evt_cause == HC_TIMEOUT) ? '0 : wb_pc;
                    drain_nx = DRAIN_LOAD;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 4'd0)
                    state_nx = ST_REPORT;
                else
                    drain_nx = drain_cnt - 1'b1;
            end
            ST_REPORT: begin
                if (report_ready)
                    state_nx = ST_HALTED;
            end
            ST_HALTED: begin
                if (restart) begin
                    state_nx = ST_RUN;
                    ret_nx   = '0;
                    cyc_nx   = '0;
                    cause_nx = HC_NONE;
                    pc_nx    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_RUN;
            drain_cnt     <= '0;
            retired_count <= '0;
            cycle_count   <= '0;
            halt_cause    <= HC_NONE;
            halt_pc       <= '0;
        end else begin
            state         <= state_nx;
            drain_cnt     <= drain_nx;
            retired_count <= ret_nx;
            cycle_count   <= cyc_nx;
            halt_cause    <= cause_nx;
            halt_pc       <= pc_nx;
        end
    end

    assign report_valid = (state == ST_REPORT);
    assign halted       = (state == ST_REPORT) || (state == ST_HALTED);

endmodule

// File: tb/tb_riscv_retire_monitor.sv
// Self-checking bench for riscv_retire_monitor: directed vector table,
// hand-written corner sequences and random traffic against a timing model.
module tb_riscv_retire_monitor;

    localparam int PW = 32;
    localparam int CW = 32;
    localparam int DC = 3;
    localparam int MC = 200;
    localparam logic [6:0] SYS = 7'b1110011;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb_valid = 1'b0;
    logic [6:0]    wb_opcode = '0;
    logic [PW-1:0] wb_pc = '0;
    logic          restart = 1'b0;
    logic          report_ready = 1'b0;
    logic          report_valid;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [PW-1:0] halt_pc;
    logic [CW-1:0] retired_count;
    logic [CW-1:0] cycle_count;

    always #5 clk = ~clk;

    riscv_retire_monitor #(
        .PC_WIDTH(PW), .CNT_WIDTH(CW),
        .DRAIN_CYCLES(DC), .MAX_CYCLES(MC)
    ) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_pc(wb_pc),
        .restart(restart),
        .report_valid(report_valid), .report_ready(report_ready),
        .halted(halted), .halt_cause(halt_cause), .halt_pc(halt_pc),
        .retired_count(retired_count), .cycle_count(cycle_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Legal list; the last entry is SYSTEM
    logic [6:0] legal_ops [11] = '{
        7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
        7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
        7'b1110011
    };

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        for (int i = 0; i < 11; i++)
            if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Model: tracks the halt edge and derives phase from elapsed edges
    bit          m_run;
    bit          m_acked;
    logic [31:0] m_ret, m_cyc, m_pc;
    logic [1:0]  m_cause;
    int          m_t = 0;
    int          m_evt = 0;

    task automatic model_reset();
        m_run = 1'b1; m_acked = 1'b0;
        m_ret = '0; m_cyc = '0; m_pc = '0; m_cause = '0;
        m_evt = 0;
    endtask

    task automatic model_edge(input bit v, input logic [6:0] op,
                              input logic [31:0] pc, input bit rdy,
                              input bit rs);
        logic [1:0] c;
        c = 2'd0;
        if (m_run) begin
            if (v && op == SYS) c = 2'd1;
            else if (v && !is_legal(op)) c = 2'd2;
            else if (MC != 0 && m_cyc == MC - 1) c = 2'd3;
            if (m_cyc != 32'hFFFF_FFFF) m_cyc++;
            if (v && is_legal(op) && m_ret != 32'hFFFF_FFFF) m_ret++;
            if (c != 2'd0) begin
                m_run = 1'b0; m_evt = m_t; m_cause = c;
                m_pc = (c == 2'd3) ? 32'd0 : pc;
                m_acked = 1'b0;
            end
        end else if (m_t > m_evt + DC) begin
            if (m_acked) begin
                if (rs) model_reset();
            end else if (rdy) begin
                m_acked = 1'b1;
            end
        end
        m_t++;
    endtask

    function automatic bit exp_halted();
        return !m_run && (m_t - 1 >= m_evt + DC);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".report_valid"}, report_valid, exp_halted() && !m_acked);
        chk({tag, ".halted"}, halted, exp_halted());
        chk({tag, ".halt_cause"}, halt_cause, m_run ? 2'd0 : m_cause);
        chk({tag, ".halt_pc"}, halt_pc, m_run ? 32'd0 : m_pc);
        chk({tag, ".retired_count"}, retired_count, m_ret);
        chk({tag, ".cycle_count"}, cycle_count, m_cyc);
    endtask

    task automatic cyc(input bit v, input logic [6:0] op,
                       input logic [31:0] pc, input bit rdy, input bit rs,
                       input string tag);
        wb_valid = v; wb_opcode = op; wb_pc = pc;
        report_ready = rdy; restart = rs;
        @(posedge clk);
        model_edge(v, op, pc, rdy, rs);
        @(negedge clk);
        check_model(tag);
    endtask

    typedef struct {
        bit          v;
        logic [6:0]  op;
        logic [31:0] pc;
        bit          rdy;
        bit          rs;
        bit          rv;
        bit          hl;
        logic [1:0]  cause;
        logic [31:0] hpc;
        logic [31:0] ret;
        logic [31:0] cy;
    } vec_t;

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, legal_ops[i], 32'(i * 4), 1'b1, 1'b0,
                       1'b0, 1'b0, 2'd0, 32'd0, 32'(i + 1), 32'(i + 1)};
        tbl[10] = '{1'b1, SYS, 32'h28, 1'b1, 1'b0,
                    1'b0, 1'b0, 2'd1, 32'h28, 32'd11, 32'd11};
        tbl[11] = '{1'b1, 7'b0010011, 32'h2c, 1'b1, 1'b0,
                    1'b0, 1'b0, 2'd1, 32'h28, 32'd11, 32'd11};
        tbl[12] = '{1'b0, 7'd0, 32'd0, 1'b1, 1'b0,
                    1'b0, 1'b0, 2'd1, 32'h28, 32'd11, 32'd11};
        tbl[13] = '{1'b0, 7'd0, 32'd0, 1'b1, 1'b0,
                    1'b1, 1'b1, 2'd1, 32'h28, 32'd11, 32'd11};
        tbl[14] = '{1'b0, 7'd0, 32'd0, 1'b1, 1'b0,
                    1'b0, 1'b1, 2'd1, 32'h28, 32'd11, 32'd11};
        tbl[15] = '{1'b0, 7'd0, 32'd0, 1'b0, 1'b0,
                    1'b0, 1'b1, 2'd1, 32'h28, 32'd11, 32'd11};

        model_reset();
        repeat (2) @(negedge clk);
        check_model("reset");
        reset = 1'b0;

        // SYSTEM at 0x28 after 10 retirements, ready held high
        for (int i = 0; i < 16; i++) begin
            string t;
            t = $sformatf("tbl%0d", i);
            wb_valid = tbl[i].v; wb_opcode = tbl[i].op; wb_pc = tbl[i].pc;
            report_ready = tbl[i].rdy; restart = tbl[i].rs;
            @(posedge clk);
            model_edge(tbl[i].v, tbl[i].op, tbl[i].pc, tbl[i].rdy, tbl[i].rs);
            @(negedge clk);
            chk({t, ".report_valid"}, report_valid, tbl[i].rv);
            chk({t, ".halted"}, halted, tbl[i].hl);
            chk({t, ".halt_cause"}, halt_cause, tbl[i].cause);
            chk({t, ".halt_pc"}, halt_pc, tbl[i].hpc);
            chk({t, ".retired_count"}, retired_count, tbl[i].ret);
            chk({t, ".cycle_count"}, cycle_count, tbl[i].cy);
        end

        cyc(0, 7'd0, 0, 0, 1, "restart1");
        chk("restart1.halted", halted, 1'b0);
        chk("restart1.cycle_count", cycle_count, 32'd0);

        // Illegal opcode, retirements in DRAIN, restart ignored in REPORT
        for (int i = 0; i < 5; i++)
            cyc(1, legal_ops[i], 32'(i * 4), 0, 0, "ill_pre");
        cyc(1, 7'b1111111, 32'h14, 0, 0, "ill_evt");
        for (int i = 0; i < DC; i++)
            cyc(1, 7'b0110011, 32'h18, 0, 0, "ill_drain");
        cyc(0, 7'd0, 0, 0, 1, "ill_rs_in_report");
        chk("ill.report_valid", report_valid, 1'b1);
        chk("ill.retired_count", retired_count, 32'd5);
        chk("ill.halt_cause", halt_cause, 2'd2);
        chk("ill.halt_pc", halt_pc, 32'h14);
        cyc(0, 7'd0, 0, 1, 0, "ill_ack");
        cyc(0, 7'd0, 0, 0, 1, "ill_restart");

        // Timeout with a slow host
        for (int i = 0; i < MC; i++)
            cyc(0, 7'd0, 0, 0, 0, "to_run");
        chk("to.halt_cause", halt_cause, 2'd3);
        chk("to.halt_pc", halt_pc, 32'd0);
        chk("to.cycle_count", cycle_count, 32'(MC));
        for (int i = 0; i < DC + 5; i++)
            cyc(0, 7'd0, 0, 0, 0, "to_wait");
        chk("to.report_valid_held", report_valid, 1'b1);
        cyc(0, 7'd0, 0, 1, 0, "to_ack");
        chk("to.report_valid_clr", report_valid, 1'b0);
        cyc(0, 7'd0, 0, 0, 1, "to_restart");

        // SYSTEM on the timeout edge
        for (int i = 0; i < MC - 1; i++)
            cyc(0, 7'd0, 0, 0, 0, "same_run");
        cyc(1, SYS, 32'h40, 0, 0, "same_evt");
        chk("same.halt_cause", halt_cause, 2'd1);
        chk("same.halt_pc", halt_pc, 32'h40);
        for (int i = 0; i < DC; i++)
            cyc(0, 7'd0, 0, 1, 0, "same_drain");
        cyc(0, 7'd0, 0, 1, 0, "same_ack");
        cyc(0, 7'd0, 0, 0, 1, "same_restart");

        // Asynchronous reset one cycle into DRAIN
        cyc(1, SYS, 32'h50, 0, 0, "rst_evt");
        cyc(0, 7'd0, 0, 0, 0, "rst_drain");
        #2 reset = 1'b1;
        #1;
        chk("async_rst.report_valid", report_valid, 1'b0);
        chk("async_rst.halted", halted, 1'b0);
        chk("async_rst.halt_cause", halt_cause, 2'd0);
        chk("async_rst.halt_pc", halt_pc, 32'd0);
        chk("async_rst.retired_count", retired_count, 32'd0);
        chk("async_rst.cycle_count", cycle_count, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(1, legal_ops[i], 32'(i * 4), 0, 0, "post_rst");
        chk("post_rst.retired_count", retired_count, 32'd3);

        // Random traffic; second half rarely halts so timeouts occur
        for (int i = 0; i < 4000; i++) begin
            bit v;
            bit rdy;
            bit rs;
            logic [6:0] op;
            int r;
            r = $urandom_range(0, 99);
            v = ($urandom_range(0, 99) < 70);
            if (i < 2000 && r < 2) op = SYS;
            else if (i < 2000 && r < 4) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 9)];
            rdy = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) == 0);
            cyc(v, op, $urandom, rdy, rs, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
